// File: rtl/srff_bank_pkg.sv
// Shared definitions for the srff_bank slice: conflict policy encodings,
// conflict counter geometry and the per-channel next-state function.
package srff_bank_pkg;

  localparam int SRFF_MODE_RDOM   = 0;
  localparam int SRFF_MODE_SDOM   = 1;
  localparam int SRFF_MODE_HOLD   = 2;
  localparam int SRFF_MODE_TOGGLE = 3;

  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = 8'd255;

  // Toggle mode flips only on the first cycle of a conflict, then holds.
  function automatic logic next_q(input int mode, input logic fs, input logic fr,
                                  input logic q, input logic onset);
    logic nq;
    nq = q;
    if (fs && !fr) begin
      nq = 1'b1;
    end else if (!fs && fr) begin
      nq = 1'b0;
    end else if (fs && fr) begin
      if (mode == SRFF_MODE_RDOM) nq = 1'b0;
      else if (mode == SRFF_MODE_SDOM) nq = 1'b1;
      else if (mode == SRFF_MODE_TOGGLE && onset) nq = ~q;
    end
    return nq;
  endfunction

endpackage

// File: rtl/srff_bank_if.sv
// Request/status bundle between the switch front end (master) and the SR bank (slave).
interface srff_bank_if import srff_bank_pkg::*; #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (output s, r, clr, input q, q_n, conflict, conflict_cnt);
  modport slave  (input s, r, clr, output q, q_n, conflict, conflict_cnt);
endinterface

// File: rtl/srff_input_filter.sv
// One raw input path: SYNC_STAGES-deep synchroniser followed by a glitch filter
// that only follows the input after FILTER consecutive differing cycles.
module srff_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic f
);

  logic y;

  if (SYNC_STAGES < 0 || SYNC_STAGES > 3 || FILTER < 0 || FILTER > 15) begin : g_bad_param
    $error("srff_input_filter: SYNC_STAGES must be 0..3 and FILTER 0..15");
  end

  // synchroniser stage
  if (SYNC_STAGES == 0) begin : g_nosync
    assign y = d;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_p0;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_p0 <= '0;
      end else begin
        sync_p0[0] <= d;
        for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      end
    end
    assign y = sync_p0[SYNC_STAGES-1];
  end

  // glitch filter stage
  if (FILTER == 0) begin : g_nofilt
    assign f = y;
  end else begin : g_filt
    logic       f_p1;
    logic [3:0] cnt_p1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        f_p1   <= 1'b0;
        cnt_p1 <= '0;
      end else if (y == f_p1) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == 4'(FILTER - 1)) begin
        f_p1   <= y;
        cnt_p1 <= '0;
      end else begin
        cnt_p1 <= cnt_p1 + 4'd1;
      end
    end
    assign f = f_p1;
  end

endmodule

// File: rtl/srff_bank.sv
// Bank of WIDTH clocked SR flip-flops with filtered inputs, a selectable S=R=1
// policy, per-channel conflict flags and a saturating conflict-onset counter.
module srff_bank import srff_bank_pkg::*; #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER      = 3,
  parameter int               MODE        = 0,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        rst_n,
  srff_bank_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32 || MODE < 0 || MODE > 3) begin : g_bad_param
    $error("srff_bank: WIDTH must be 1..32 and MODE 0..3");
  end

  logic [WIDTH-1:0] fs;
  logic [WIDTH-1:0] fr;
  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] onset;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_p2;
  logic [WIDTH-1:0] conf_p2;
  logic [WIDTH-1:0] both_d_p2;
  logic [CNT_W-1:0] cnt_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // input conditioning stage
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    srff_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_s (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.s[i]),
      .f     (fs[i])
    );
    srff_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_r (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.r[i]),
      .f     (fr[i])
    );
  end

  // Onset history is kept through clr so a conflict spanning clr is not recounted.
  assign both  = fs & fr;
  assign onset = both & ~both_d_p2;

  always_comb begin
    q_nxt = q_p2;
    for (int i = 0; i < WIDTH; i++) begin
      q_nxt[i] = next_q(MODE, fs[i], fr[i], q_p2[i], onset[i]);
    end
  end

  // state register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p2      <= RESET_VAL;
      conf_p2   <= '0;
      both_d_p2 <= '0;
      cnt_p2    <= '0;
    end else begin
      both_d_p2 <= both;
      if (bus.clr) begin
        q_p2    <= RESET_VAL;
        conf_p2 <= '0;
        cnt_p2  <= '0;
      end else begin
        q_p2    <= q_nxt;
        conf_p2 <= both;
        if (|onset) cnt_p2 <= sat_inc(cnt_p2);
      end
    end
  end

  assign bus.q            = q_p2;
  assign bus.q_n          = ~q_p2;
  assign bus.conflict     = conf_p2;
  assign bus.conflict_cnt = cnt_p2;

endmodule
